// File: rtl/bus_master_port.sv
// bus_master_port: serialises user read/write requests onto a 1-bit address/data slave bus.
// Optional wait-state watchdog is enabled by defining BUS_MASTER_TIMEOUT_EN.
module bus_master_port #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wren,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              m_valid,
    output logic              m_wren,
    output logic              m_addr,
    output logic              m_wdata,
    input  logic              s_ready,
    input  logic              s_valid,
    input  logic              s_rdata
);
    localparam int MW   = ADDR_W > DATA_W ? ADDR_W : DATA_W;
    localparam int CMAX = MW > TIMEOUT_CYC ? MW : TIMEOUT_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    typedef enum logic [2:0] {IDLE, ADDR, WAIT_RDY, WDATA, WAIT_RD, RDATA, RESP} state_t;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, rsp_rdata_q, rsp_rdata_d;
    logic              rsp_valid_q, rsp_valid_d, m_valid_q, m_valid_d, m_wren_q, m_wren_d;
    logic              m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
`ifdef BUS_MASTER_TIMEOUT_EN
    logic              rsp_err_q, rsp_err_d;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif
    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign m_valid   = m_valid_q;
    assign m_wren    = m_wren_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    // next state and next registered bus/response outputs; cnt also serves as the wait watchdog
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wren_d      = wren_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        m_valid_d   = m_valid_q;
        m_wren_d    = m_wren_q;
        m_addr_d    = 1'b0;
        m_wdata_d   = 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
        rsp_err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: if (req_valid) begin
                state_d   = ADDR;
                wren_d    = req_wren;
                addr_d    = req_addr << 1;
                wdata_d   = req_wdata;
                rdata_d   = '0;
                cnt_d     = '0;
                m_valid_d = 1'b1;
                m_wren_d  = req_wren;
                m_addr_d  = req_addr[ADDR_W-1];
            end
            ADDR: if (cnt_q == CW'(ADDR_W - 1)) begin
                cnt_d     = '0;
                m_valid_d = 1'b0;
                state_d   = wren_q ? WAIT_RDY : WAIT_RD;
            end else begin
                cnt_d    = cnt_q + CW'(1);
                m_addr_d = addr_q[ADDR_W-1];
                addr_d   = addr_q << 1;
            end
            WAIT_RDY: if (s_ready) begin
                state_d   = WDATA;
                cnt_d     = '0;
                m_valid_d = 1'b1;
                m_wdata_d = wdata_q[DATA_W-1];
                wdata_d   = wdata_q << 1;
            end
`ifdef BUS_MASTER_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                state_d     = RESP;
                cnt_d       = '0;
                m_wren_d    = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
`endif
            WDATA: if (cnt_q == CW'(DATA_W - 1)) begin
                state_d     = RESP;
                cnt_d       = '0;
                m_valid_d   = 1'b0;
                m_wren_d    = 1'b0;
                rsp_valid_d = 1'b1;
            end else begin
                cnt_d     = cnt_q + CW'(1);
                m_wdata_d = wdata_q[DATA_W-1];
                wdata_d   = wdata_q << 1;
            end
            WAIT_RD: if (s_valid) begin
                state_d = RDATA;
                cnt_d   = CW'(1);
                rdata_d = (rdata_q << 1) | DATA_W'(s_rdata);
            end
`ifdef BUS_MASTER_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                state_d     = RESP;
                cnt_d       = '0;
                m_wren_d    = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
`endif
            RDATA: begin
                rdata_d = (rdata_q << 1) | DATA_W'(s_rdata);
                if (cnt_q == CW'(DATA_W - 1)) begin
                    state_d     = RESP;
                    cnt_d       = '0;
                    m_wren_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rdata_d;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state, captured request and registered outputs; reset aborts any transaction silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wren_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            m_valid_q   <= 1'b0;
            m_wren_q    <= 1'b0;
            m_addr_q    <= 1'b0;
            m_wdata_q   <= 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wren_q      <= wren_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            m_valid_q   <= m_valid_d;
            m_wren_q    <= m_wren_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
`ifdef BUS_MASTER_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end
endmodule
